fib_port_writer: RTL and testbench

FIB_PORT_WRITER -- requirements
Module: fib_port_writer

---
 rtl/fib_port_writer.sv | 126 ++++++++++++
 tb/tb_fib_port_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_port_writer.sv
// Writes a framed Fibonacci sequence (BEGIN_SYM, ascending terms, descending terms, END_SYM) to one port.
// Outputs are registered; the first write appears the cycle after start, and stall holds the current write.
module fib_port_writer #(
  parameter logic [29:0] TEST_PORT = 30'h40,
  parameter logic [31:0] BEGIN_SYM = 32'h00000932,
  parameter logic [31:0] END_SYM   = 32'h00000D5D,
  parameter int          NUM_TERMS = 16,
  parameter int          GAP       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

  localparam logic [6:0] LAST_IDX = 7'(2 * NUM_TERMS + 1);
  localparam logic [6:0] ASC_LAST = 7'(NUM_TERMS);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state, state_n;
  logic [6:0]  idx, idx_n;
  logic [31:0] fa, fb, fa_n, fb_n;
  logic [3:0]  gap_cnt, gap_cnt_n;
  logic [29:0] addr_n;
  logic [31:0] data_n;
  logic        wen_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      fa      <= '0;
      fb      <= '0;
      gap_cnt <= '0;
      wen     <= 1'b0;
      addr    <= '0;
      data    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      fa      <= fa_n;
      fb      <= fb_n;
      gap_cnt <= gap_cnt_n;
      wen     <= wen_n;
      addr    <= addr_n;
      data    <= data_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // fa always holds the term to emit; fb is its partner in the recurrence.
  // Descending steps reuse the final ascending pair, so the peak term repeats.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    fa_n      = fa;
    fb_n      = fb;
    gap_cnt_n = gap_cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n   = S_WRITE;
          idx_n     = '0;
          fa_n      = 32'd0;
          fb_n      = 32'd1;
          gap_cnt_n = '0;
        end
      end
      S_WRITE: begin
        if (!stall) begin
          if (idx == LAST_IDX) begin
            state_n = S_DONE;
          end else begin
            state_n   = S_GAP;
            gap_cnt_n = '0;
            idx_n     = idx + 7'd1;
          end
          if (idx >= 7'd1 && idx < ASC_LAST) begin
            fa_n = fb;
            fb_n = fa + fb;
          end else if (idx > ASC_LAST && idx < LAST_IDX - 7'd1) begin
            fa_n = fb - fa;
            fb_n = fa;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = S_WRITE;
        end else begin
          gap_cnt_n = gap_cnt + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    wen_n  = 1'b0;
    addr_n = '0;
    data_n = '0;
    busy_n = (state_n == S_WRITE) || (state_n == S_GAP);
    done_n = (state_n == S_DONE);
    if (state_n == S_WRITE) begin
      wen_n  = 1'b1;
      addr_n = TEST_PORT;
      if (idx_n == 7'd0)
        data_n = BEGIN_SYM;
      else if (idx_n == LAST_IDX)
        data_n = END_SYM;
      else
        data_n = fa_n;
    end
  end

endmodule

// File: tb/tb_fib_port_writer.sv
// Randomized and directed bench for fib_port_writer against a cycle-timeline reference model.
`timescale 1ns/1ps
module tb_fib_port_writer;

  localparam int MAXC = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stall = 1'b0, start2 = 1'b0, stall2 = 1'b0;
  logic [29:0] addr, addr2;
  logic [31:0] data, data2;
  logic wen, busy, done, wen2, busy2, done2;

  always #5 clk = ~clk;

  fib_port_writer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .addr(addr), .data(data), .wen(wen), .busy(busy), .done(done)
  );

  fib_port_writer #(.NUM_TERMS(2), .GAP(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stall(stall2),
    .addr(addr2), .data(data2), .wen(wen2), .busy(busy2), .done(done2)
  );

  // Per-cycle stimulus (sampled at the edge ending cycle c) and observation vectors
  // {wen, busy, done, addr, data} seen during cycle c.
  bit          start_v [MAXC];
  bit          stall_v [MAXC];
  bit          rst_v   [MAXC];
  logic [64:0] obs_v   [MAXC];
  logic [64:0] exp_v   [MAXC];

  int total = 0;
  int bad   = 0;

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      start_v[i] = 1'b0;
      stall_v[i] = 1'b0;
      rst_v[i]   = 1'b0;
      exp_v[i]   = '0;
    end
  endtask

  task automatic run(input int sel, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rst    = rst_v[c];
      start  = (sel == 0) ? start_v[c] : 1'b0;
      stall  = (sel == 0) ? stall_v[c] : 1'b0;
      start2 = (sel == 1) ? start_v[c] : 1'b0;
      stall2 = (sel == 1) ? stall_v[c] : 1'b0;
      @(negedge clk);
      obs_v[c] = (sel == 0) ? {wen, busy, done, addr, data} : {wen2, busy2, done2, addr2, data2};
      @(posedge clk);
      #1;
    end
    rst = 1'b0; start = 1'b0; stall = 1'b0; start2 = 1'b0; stall2 = 1'b0;
  endtask

  task automatic put(input int c, input logic w, input logic b, input logic d, input logic [31:0] dat);
    if (c < MAXC) exp_v[c] = {w, b, d, (w ? 30'h40 : 30'h0), dat};
  endtask

  // Reference timeline: the word list comes straight from the Fibonacci definition,
  // each write lasts one cycle plus one per stalled cycle, then gap idle cycles.
  task automatic build_exp(input int n, input int gap, input int s0);
    logic [31:0] fib [48];
    logic [31:0] w   [96];
    int c;
    bit hold;
    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int i = 2; i < n; i++) fib[i] = fib[i-1] + fib[i-2];
    w[0] = 32'h932;
    for (int i = 0; i < n; i++) begin
      w[1+i]   = fib[i];
      w[n+1+i] = fib[n-1-i];
    end
    w[2*n+1] = 32'hD5D;
    c = s0 + 1;
    for (int k = 0; k <= 2*n+1; k++) begin
      do begin
        put(c, 1'b1, 1'b1, 1'b0, w[k]);
        hold = (c < MAXC) ? stall_v[c] : 1'b0;
        c++;
      end while (hold);
      if (k != 2*n+1)
        for (int g = 0; g < gap; g++) begin
          put(c, 1'b0, 1'b1, 1'b0, 32'd0);
          c++;
        end
    end
    while (c < MAXC) begin
      put(c, 1'b0, 1'b0, 1'b1, 32'd0);
      c++;
    end
  endtask

  task automatic test_reset();
    clear_stim();
    for (int c = 0; c < 3; c++) begin
      rst_v[c] = 1'b1;
      start_v[c] = 1'b1;
      stall_v[c] = 1'b1;
    end
    run(0, 5);
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (obs_v[c] !== 65'd0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=%h", c, obs_v[c], 65'd0);
      end
    end
    total++;
    if ({wen2, busy2, done2, addr2, data2} !== 65'd0) begin
      bad++;
      $display("FAIL reset_dut2 got=%h want=0", {wen2, busy2, done2, addr2, data2});
    end
  endtask

  task automatic test_default();
    clear_stim();
    start_v[0] = 1'b1;
    run(0, 75);
    build_exp(16, 1, 0);
    for (int c = 1; c < 75; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL default cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_restart_done();
    clear_stim();
    start_v[0] = 1'b1;
    run(0, 75);
    build_exp(16, 1, 0);
    total++;
    if (obs_v[0] !== {3'b001, 62'd0}) begin
      bad++;
      $display("FAIL restart_in_done got=%h want=%h", obs_v[0], {3'b001, 62'd0});
    end
    for (int c = 1; c < 75; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL restart cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_stall();
    clear_stim();
    start_v[0] = 1'b1;
    for (int c = 11; c <= 13; c++) stall_v[c] = 1'b1;
    run(0, 78);
    build_exp(16, 1, 0);
    for (int c = 1; c < 78; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL stall cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
    total++;
    if (obs_v[70][62] !== 1'b0 || obs_v[71][62] !== 1'b1 || obs_v[14] !== {3'b110, 30'h40, 32'd3}) begin
      bad++;
      $display("FAIL stall_timing done70=%b done71=%b cyc14=%h want done70=0 done71=1 cyc14=%h",
               obs_v[70][62], obs_v[71][62], obs_v[14], {3'b110, 30'h40, 32'd3});
    end
  endtask

  task automatic test_busy_start();
    clear_stim();
    start_v[0] = 1'b1;
    start_v[10] = 1'b1;
    start_v[40] = 1'b1;
    run(0, 75);
    build_exp(16, 1, 0);
    for (int c = 1; c < 75; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL busy_start cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_random_stall();
    for (int it = 0; it < 3; it++) begin
      clear_stim();
      start_v[0] = 1'b1;
      for (int c = 0; c < 150; c++) stall_v[c] = ($urandom_range(0, 9) < 3);
      build_exp(16, 1, 0);
      for (int k = 0; k < 3; k++) begin
        int p;
        p = $urandom_range(1, 200);
        if (exp_v[p][63] === 1'b1) start_v[p] = 1'b1;
      end
      run(0, 260);
      for (int c = 1; c < 260; c++) begin
        total++;
        if (obs_v[c] !== exp_v[c]) begin
          bad++;
          $display("FAIL random_stall it=%0d cyc=%0d got=%h want=%h", it, c, obs_v[c], exp_v[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    start_v[0] = 1'b1;
    rst_v[41] = 1'b1;
    start_v[45] = 1'b1;
    build_exp(16, 1, 0);
    build_exp(16, 1, 45);
    for (int c = 42; c <= 45; c++) exp_v[c] = '0;
    run(0, 60);
    for (int c = 1; c < 60; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_small_gap();
    clear_stim();
    start_v[0] = 1'b1;
    run(1, 30);
    build_exp(2, 3, 0);
    for (int c = 1; c < 30; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL small_gap cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
    clear_stim();
    start_v[0] = 1'b1;
    for (int c = 0; c < 30; c++) stall_v[c] = ($urandom_range(0, 3) == 0);
    run(1, 70);
    build_exp(2, 3, 0);
    for (int c = 1; c < 70; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL small_gap_stall cyc=%0d got=%h want=%h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  initial begin
    clear_stim();
    @(posedge clk);
    #1;
    test_reset();
    test_default();
    test_restart_done();
    test_stall();
    test_busy_start();
    test_random_stall();
    test_reset_mid();
    test_small_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
